// File: rtl/sd_spi_responder_if.sv
// SD-over-SPI link plus the responder's byte-memory read port.
// master = host/memory side, slave = card responder.
interface sd_spi_responder_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;

  modport master (
    output sclk, cs_n, mosi, mem_data,
    input  miso, mem_rd, mem_addr
  );

  modport slave (
    input  sclk, cs_n, mosi, mem_data,
    output miso, mem_rd, mem_addr
  );
endinterface

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card model: oversamples the host link, decodes command frames,
// answers R1/R7 and streams CMD17 single-block reads from a byte memory.
module sd_spi_responder #(
  parameter int unsigned INIT_POLLS = 2,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned NCR_BYTES  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  sd_spi_responder_if.slave   bus,
  output logic                card_ready,
  output logic                busy
);
  typedef enum logic [2:0] {HUNT, CMD, NCR, RESP, TOKEN, DATA, CRC} state_t;

  localparam logic [15:0] POLL_LIM = 16'(INIT_POLLS);
  localparam logic [9:0]  NCR_LAST = 10'(NCR_BYTES - 1);

  logic [1:0] sclk_s, cs_s, mosi_s;
  logic       sclk_d;
  logic       sclk_rise, sclk_fall, mosi_b;

  state_t            state;
  logic [45:0]       cmd_sh;     // frame bits 46..1 once the end bit arrives
  logic [5:0]        cmd_cnt;
  logic [2:0]        bit_idx;
  logic [9:0]        cnt;
  logic [7:0]        sh;
  logic              fin;
  logic [4:0][7:0]   resp;
  logic [2:0]        resp_len;
  logic              data_phase;
  logic [ADDR_W-10:0] blk;
  logic              app;
  logic [15:0]       polls;
  logic [7:0]        nxt_data;
  logic              mem_rd_q;
  logic              miso_r, mem_rd_r;
  logic [ADDR_W-1:0] mem_addr_r;

  logic [5:0]        f_idx;
  logic              idle;
  logic [4:0][7:0]   dec_resp;
  logic [2:0]        dec_len;
  logic              dec_dp, dec_app, dec_clr, dec_poll, dec_ready;
  logic              fetch;
  logic [8:0]        fetch_idx;

  assign sclk_rise = sclk_s[1] & ~sclk_d;
  assign sclk_fall = ~sclk_s[1] & sclk_d;
  assign mosi_b    = mosi_s[1];
  assign f_idx     = cmd_sh[44:39];
  assign idle      = ~card_ready;

  assign bus.miso     = miso_r;
  assign bus.mem_rd   = mem_rd_r;
  assign bus.mem_addr = mem_addr_r;

  // Next data byte is fetched while the byte before it starts shifting.
  assign fetch     = (state == TOKEN && cnt == 10'd2) || (state == DATA && cnt != 10'd511);
  assign fetch_idx = (state == TOKEN) ? 9'd0 : cnt[8:0] + 9'd1;

  always_comb begin
    dec_resp  = '0;
    dec_len   = 3'd1;
    dec_dp    = 1'b0;
    dec_app   = 1'b0;
    dec_clr   = 1'b0;
    dec_poll  = 1'b0;
    dec_ready = 1'b0;
    if (f_idx == 6'd0) begin
      dec_resp[0] = 8'h01;
      dec_clr     = 1'b1;
    end else if (f_idx == 6'd8) begin
      dec_resp[0] = {7'b0, idle};
      dec_resp[3] = {4'h0, cmd_sh[18:15]};
      dec_resp[4] = cmd_sh[14:7];
      dec_len     = 3'd5;
    end else if (f_idx == 6'd55) begin
      dec_resp[0] = {7'b0, idle};
      dec_app     = 1'b1;
    end else if (f_idx == 6'd41 && app) begin
      if (polls < POLL_LIM) begin
        dec_resp[0] = 8'h01;
        dec_poll    = 1'b1;
      end else begin
        dec_resp[0] = 8'h00;
        dec_ready   = 1'b1;
      end
    end else if (f_idx == 6'd17 && card_ready) begin
      dec_resp[0] = 8'h00;
      dec_dp      = 1'b1;
    end else if (f_idx == 6'd17) begin
      dec_resp[0] = 8'h05;
    end else begin
      dec_resp[0] = {5'b0, 1'b1, 1'b0, idle};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s     <= '0;
      cs_s       <= '1;
      mosi_s     <= '1;
      sclk_d     <= 1'b0;
      state      <= HUNT;
      cmd_sh     <= '0;
      cmd_cnt    <= '0;
      bit_idx    <= '0;
      cnt        <= '0;
      sh         <= '1;
      fin        <= 1'b0;
      resp       <= '0;
      resp_len   <= 3'd1;
      data_phase <= 1'b0;
      blk        <= '0;
      app        <= 1'b0;
      polls      <= '0;
      nxt_data   <= '0;
      mem_rd_q   <= 1'b0;
      miso_r     <= 1'b1;
      mem_rd_r   <= 1'b0;
      mem_addr_r <= '0;
      card_ready <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sclk_s   <= {sclk_s[0], bus.sclk};
      cs_s     <= {cs_s[0], bus.cs_n};
      mosi_s   <= {mosi_s[0], bus.mosi};
      sclk_d   <= sclk_s[1];
      mem_rd_r <= 1'b0;
      mem_rd_q <= mem_rd_r;
      if (mem_rd_q) nxt_data <= bus.mem_data;

      if (cs_s[1]) begin
        state   <= HUNT;
        cmd_cnt <= '0;
        bit_idx <= '0;
        cnt     <= '0;
        fin     <= 1'b0;
        busy    <= 1'b0;
        miso_r  <= 1'b1;
      end else begin
        case (state)
          HUNT: begin
            if (sclk_rise && !mosi_b) begin
              state   <= CMD;
              cmd_sh  <= '0;
              cmd_cnt <= 6'd1;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              if (cmd_cnt == 6'd47) begin
                if (cmd_sh[45] && mosi_b) begin
                  resp       <= dec_resp;
                  resp_len   <= dec_len;
                  data_phase <= dec_dp;
                  blk        <= cmd_sh[ADDR_W-3:7];
                  app        <= dec_app;
                  if (dec_clr) begin
                    card_ready <= 1'b0;
                    polls      <= '0;
                  end
                  if (dec_poll)  polls      <= polls + 16'd1;
                  if (dec_ready) card_ready <= 1'b1;
                  state   <= NCR;
                  cnt     <= '0;
                  sh      <= 8'hFF;
                  bit_idx <= '0;
                  fin     <= 1'b0;
                  busy    <= 1'b1;
                end else begin
                  state <= HUNT;
                end
              end else begin
                cmd_sh  <= {cmd_sh[44:0], mosi_b};
                cmd_cnt <= cmd_cnt + 6'd1;
              end
            end
          end
          default: begin
            if (sclk_fall) begin
              if (fin) begin
                state  <= HUNT;
                busy   <= 1'b0;
                miso_r <= 1'b1;
                fin    <= 1'b0;
              end else begin
                miso_r  <= sh[7];
                sh      <= {sh[6:0], 1'b1};
                bit_idx <= bit_idx + 3'd1;
                if (bit_idx == 3'd0 && fetch) begin
                  mem_rd_r   <= 1'b1;
                  mem_addr_r <= {blk, fetch_idx};
                end
                // LSB just went out: preload the byte whose MSB leaves on the next fall.
                if (bit_idx == 3'd7) begin
                  case (state)
                    NCR: begin
                      if (cnt == NCR_LAST) begin
                        state <= RESP;
                        cnt   <= '0;
                        sh    <= resp[0];
                      end else begin
                        cnt <= cnt + 10'd1;
                        sh  <= 8'hFF;
                      end
                    end
                    RESP: begin
                      if (cnt[2:0] != resp_len - 3'd1) begin
                        cnt <= cnt + 10'd1;
                        sh  <= resp[cnt[2:0] + 3'd1];
                      end else if (data_phase) begin
                        state <= TOKEN;
                        cnt   <= '0;
                        sh    <= 8'hFF;
                      end else begin
                        fin <= 1'b1;
                      end
                    end
                    TOKEN: begin
                      if (cnt == 10'd2) begin
                        state <= DATA;
                        cnt   <= '0;
                        sh    <= nxt_data;
                      end else begin
                        cnt <= cnt + 10'd1;
                        sh  <= (cnt == 10'd1) ? 8'hFE : 8'hFF;
                      end
                    end
                    DATA: begin
                      if (cnt == 10'd511) begin
                        state <= CRC;
                        cnt   <= '0;
                        sh    <= 8'hFF;
                      end else begin
                        cnt <= cnt + 10'd1;
                        sh  <= nxt_data;
                      end
                    end
                    CRC: begin
                      if (cnt == 10'd1) begin
                        fin <= 1'b1;
                      end else begin
                        cnt <= cnt + 10'd1;
                        sh  <= 8'hFF;
                      end
                    end
                    default: ;
                  endcase
                end
              end
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: host-side SPI driver, byte memory
// returning addr[7:0], and hand-computed response sequences.
`timescale 1ns/1ps
module tb_sd_spi_responder;
  localparam int unsigned ADDR_W = 16;
  localparam int HALF = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic card_ready, busy;

  sd_spi_responder_if #(.ADDR_W(ADDR_W)) bus ();

  sd_spi_responder #(
    .INIT_POLLS(2),
    .ADDR_W    (ADDR_W),
    .NCR_BYTES (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .card_ready(card_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int rd_cnt = 0;
  int addr_err = 0;
  int busy_rises = 0;
  int rd_start = 0;
  logic [ADDR_W-1:0] rd_base = '0;

  always_ff @(posedge clk) if (bus.mem_rd) bus.mem_data <= bus.mem_addr[7:0];

  always @(posedge clk) begin
    if (rst_n && bus.mem_rd) begin
      if (bus.mem_addr !== rd_base + ADDR_W'(rd_cnt - rd_start)) addr_err++;
      rd_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      bus.mosi = tx[i];
      tick(HALF);
      rx[i] = bus.miso;
      if (busy) busy_rises++;
      bus.sclk = 1'b1;
      tick(HALF);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic send_raw(input logic [47:0] frame);
    logic [7:0] rx;
    for (int b = 5; b >= 0; b--) xfer(frame[b*8 +: 8], rx);
  endtask

  task automatic cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
    send_raw({2'b01, idx, arg, crc});
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] exp);
    logic [7:0] rx;
    xfer(8'hFF, rx);
    check(tag, {24'h0, rx}, {24'h0, exp});
  endtask

  initial begin
    logic [7:0] rx;
    int snap;
    int err0;

    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b1;
    tick(3);
    check("rst_miso", {31'h0, bus.miso}, 32'h1);
    check("rst_mem_rd", {31'h0, bus.mem_rd}, 32'h0);
    check("rst_mem_addr", {16'h0, bus.mem_addr}, 32'h0);
    check("rst_card_ready", {31'h0, card_ready}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    tick(3);
    bus.cs_n = 1'b0;
    tick(4);

    busy_rises = 0;
    cmd(6'd0, 32'h0, 8'h95);
    rd_chk("cmd0_ncr", 8'hFF);
    rd_chk("cmd0_r1", 8'h01);
    rd_chk("cmd0_tail", 8'hFF);
    check("cmd0_busy_len", busy_rises, 32'd16);
    check("cmd0_busy_low", {31'h0, busy}, 32'h0);

    cmd(6'd8, 32'h0000_01AA, 8'h87);
    rd_chk("cmd8_ncr", 8'hFF);
    rd_chk("cmd8_r1", 8'h01);
    rd_chk("cmd8_b1", 8'h00);
    rd_chk("cmd8_b2", 8'h00);
    rd_chk("cmd8_vhs", 8'h01);
    rd_chk("cmd8_chk", 8'hAA);

    cmd(6'd5, 32'h0, 8'h01);
    rd_chk("cmd5_ncr", 8'hFF);
    rd_chk("cmd5_idle", 8'h05);

    rd_start = rd_cnt;
    cmd(6'd17, 32'h1, 8'h01);
    rd_chk("cmd17_early_ncr", 8'hFF);
    rd_chk("cmd17_early_r1", 8'h05);
    rd_chk("cmd17_early_tail", 8'hFF);
    check("cmd17_early_no_rd", rd_cnt - rd_start, 32'd0);

    for (int k = 0; k < 3; k++) begin
      cmd(6'd55, 32'h0, 8'h01);
      rd_chk("cmd55_ncr", 8'hFF);
      rd_chk("cmd55_r1", 8'h01);
      check("ready_before_acmd41", {31'h0, card_ready}, 32'h0);
      cmd(6'd41, 32'h4000_0000, 8'h01);
      rd_chk("acmd41_ncr", 8'hFF);
      rd_chk("acmd41_r1", (k == 2) ? 8'h00 : 8'h01);
      check("ready_after_acmd41", {31'h0, card_ready}, (k == 2) ? 32'h1 : 32'h0);
    end

    cmd(6'd5, 32'h0, 8'h01);
    rd_chk("cmd5_ready_ncr", 8'hFF);
    rd_chk("cmd5_ready", 8'h04);
    cmd(6'd41, 32'h0, 8'h01);
    rd_chk("cmd41_noapp_ncr", 8'hFF);
    rd_chk("cmd41_noapp", 8'h04);
    cmd(6'd55, 32'h0, 8'h01);
    rd_chk("cmd55_ready_ncr", 8'hFF);
    rd_chk("cmd55_ready", 8'h00);

    // Full single-block read of block 1 (addresses 0x200..0x3FF).
    rd_base = 16'h0200;
    rd_start = rd_cnt;
    err0 = addr_err;
    cmd(6'd17, 32'h1, 8'h01);
    rd_chk("rd_ncr", 8'hFF);
    rd_chk("rd_r1", 8'h00);
    rd_chk("rd_gap0", 8'hFF);
    rd_chk("rd_gap1", 8'hFF);
    rd_chk("rd_token", 8'hFE);
    for (int i = 0; i < 512; i++) rd_chk("rd_data", 8'(i));
    rd_chk("rd_crc0", 8'hFF);
    rd_chk("rd_crc1", 8'hFF);
    rd_chk("rd_tail", 8'hFF);
    check("rd_count", rd_cnt - rd_start, 32'd512);
    check("rd_addr_seq", addr_err - err0, 32'd0);
    check("rd_busy_low", {31'h0, busy}, 32'h0);

    // Abort in the middle of data byte 100 of block 2.
    rd_base = 16'h0400;
    rd_start = rd_cnt;
    err0 = addr_err;
    cmd(6'd17, 32'h2, 8'h01);
    rd_chk("ab_ncr", 8'hFF);
    rd_chk("ab_r1", 8'h00);
    rd_chk("ab_gap0", 8'hFF);
    rd_chk("ab_gap1", 8'hFF);
    rd_chk("ab_token", 8'hFE);
    for (int i = 0; i < 100; i++) rd_chk("ab_data", 8'(i));
    for (int b = 0; b < 3; b++) begin
      bus.mosi = 1'b1;
      tick(HALF);
      bus.sclk = 1'b1;
      tick(HALF);
      bus.sclk = 1'b0;
    end
    bus.cs_n = 1'b1;
    tick(4);
    check("ab_miso_idle", {31'h0, bus.miso}, 32'h1);
    check("ab_busy_low", {31'h0, busy}, 32'h0);
    snap = rd_cnt;
    for (int b = 0; b < 4; b++) begin
      xfer(8'hFF, rx);
      check("ab_miso_cs_high", {24'h0, rx}, 32'hFF);
    end
    check("ab_no_more_rd", rd_cnt - snap, 32'd0);
    check("ab_addr_seq", addr_err - err0, 32'd0);

    bus.cs_n = 1'b0;
    tick(4);
    cmd(6'd0, 32'h0, 8'h95);
    rd_chk("cmd0_again_ncr", 8'hFF);
    rd_chk("cmd0_again_r1", 8'h01);
    check("cmd0_again_ready", {31'h0, card_ready}, 32'h0);

    send_raw(48'h00_0000_0000_95);
    rd_chk("bad_tbit_0", 8'hFF);
    rd_chk("bad_tbit_1", 8'hFF);
    check("bad_tbit_busy", {31'h0, busy}, 32'h0);
    send_raw(48'h40_0000_0000_94);
    rd_chk("bad_end_0", 8'hFF);
    rd_chk("bad_end_1", 8'hFF);
    check("bad_end_busy", {31'h0, busy}, 32'h0);

    cmd(6'd8, 32'h0000_01AA, 8'h87);
    rd_chk("mid_ncr", 8'hFF);
    rd_chk("mid_r1", 8'h01);
    check("mid_busy", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'h0, busy}, 32'h0);
    check("arst_miso", {31'h0, bus.miso}, 32'h1);
    check("arst_mem_addr", {16'h0, bus.mem_addr}, 32'h0);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
